paddle_ctrl: RTL and testbench

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/paddle_ctrl.sv | 132 +++++++++++++
 tb/tb_paddle_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl.sv
// Paddle position controller: single step on a button press, auto-repeat after a hold delay.
// Optional build macro PADDLE_ACCEL_EN doubles the repeat step after ACCEL_FRAMES repeat steps.
module paddle_ctrl #(
   parameter int SCREEN_H     = 480,
   parameter int PADDLE_H     = 64,
   parameter int STEP         = 4,
   parameter int REPEAT_DELAY = 15,
   parameter int ACCEL_FRAMES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       up_q,
   input  logic       up_tick,
   input  logic       down_q,
   input  logic       down_tick,
   input  logic       frame_tick,
   output logic [9:0] paddle_y,
   output logic       moving,
   output logic       at_top,
   output logic       at_bottom,
   output logic [1:0] fsm_state
);

   localparam logic [10:0] YMAX      = 11'(SCREEN_H - PADDLE_H);
   localparam logic [9:0]  Y_RESET   = 10'((SCREEN_H - PADDLE_H) / 2);
   localparam logic [5:0]  HOLD_LAST = 6'(REPEAT_DELAY - 1);

   // fsm_state encoding: 0 = IDLE, 1 = HOLD, 2 = REPEAT
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_HOLD   = 2'd1;
   localparam logic [1:0] S_REPEAT = 2'd2;

   if (REPEAT_DELAY < 1 || REPEAT_DELAY > 64 || ACCEL_FRAMES < 1 || STEP < 1) begin : g_param_check
      $error("paddle_ctrl: parameter out of range");
   end

   logic [1:0]  state;
   logic        dir;
   logic [5:0]  hold_cnt;
   logic        latched_q;
   logic        opposite_q;
   logic        step_dir;
   logic [10:0] step_amt;
   logic [10:0] y_ext;
   logic [10:0] y_sum;
   logic [10:0] y_diff;
   logic [9:0]  stepped_y;

   assign latched_q  = dir ? down_q : up_q;
   assign opposite_q = dir ? up_q : down_q;

`ifdef PADDLE_ACCEL_EN
   localparam int ACW = $clog2(ACCEL_FRAMES + 1);
   localparam logic [ACW-1:0] ACCEL_LAST = ACW'(ACCEL_FRAMES);

   logic [ACW-1:0] accel_cnt;

   assign step_amt = (state == S_REPEAT && accel_cnt >= ACCEL_LAST) ? 11'(2 * STEP) : 11'(STEP);

   // Counts repeat steps within one REPEAT episode; any return to IDLE restarts it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         accel_cnt <= '0;
      end else if (state != S_REPEAT) begin
         accel_cnt <= '0;
      end else if (frame_tick && latched_q && !opposite_q && accel_cnt != ACCEL_LAST) begin
         accel_cnt <= accel_cnt + 1'b1;
      end
   end
`else
   assign step_amt = 11'(STEP);
`endif

   // Saturating step; the IDLE press step takes its direction from the tick itself.
   always_comb begin
      step_dir  = (state == S_IDLE) ? down_tick : dir;
      y_ext     = {1'b0, paddle_y};
      y_sum     = y_ext + step_amt;
      y_diff    = y_ext - step_amt;
      stepped_y = paddle_y;
      if (step_dir) begin
         stepped_y = (y_sum > YMAX) ? YMAX[9:0] : y_sum[9:0];
      end else begin
         stepped_y = (y_ext < step_amt) ? 10'd0 : y_diff[9:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         dir      <= 1'b0;
         hold_cnt <= '0;
         paddle_y <= Y_RESET;
      end else begin
         case (state)
            S_IDLE: begin
               if (up_tick ^ down_tick) begin
                  dir      <= down_tick;
                  paddle_y <= stepped_y;
                  hold_cnt <= '0;
                  state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (!latched_q || opposite_q) begin
                  state <= S_IDLE;
               end else if (frame_tick) begin
                  if (hold_cnt == HOLD_LAST) begin
                     state <= S_REPEAT;
                  end else if (hold_cnt != 6'h3f) begin
                     hold_cnt <= hold_cnt + 6'd1;
                  end
               end
            end
            S_REPEAT: begin
               if (!latched_q || opposite_q) begin
                  state <= S_IDLE;
               end else if (frame_tick) begin
                  paddle_y <= stepped_y;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign moving    = (state == S_REPEAT);
   assign at_top    = (paddle_y == 10'd0);
   assign at_bottom = (paddle_y == YMAX[9:0]);
   assign fsm_state = state;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed table, hand-written corner sequences and randomized
// stimulus against a frame-counting reference model.
module tb_paddle_ctrl;

   localparam int YMAX         = 416;
   localparam int Y_RESET      = 208;
   localparam int STEP         = 4;
   localparam int REPEAT_DELAY = 15;
   localparam int ACCEL_FRAMES = 8;
`ifdef PADDLE_ACCEL_EN
   localparam bit ACCEL = 1'b1;
`else
   localparam bit ACCEL = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       up_q, up_tick, down_q, down_tick, frame_tick;
   logic [9:0] paddle_y;
   logic       moving, at_top, at_bottom;
   logic [1:0] fsm_state;

   int n_vec;
   int n_err;

   // Reference model: press latched, frames counted since press, repeat steps taken
   bit m_active;
   bit m_dir;
   int m_frames;
   int m_rsteps;
   int m_y;

   paddle_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .up_q       (up_q),
      .up_tick    (up_tick),
      .down_q     (down_q),
      .down_tick  (down_tick),
      .frame_tick (frame_tick),
      .paddle_y   (paddle_y),
      .moving     (moving),
      .at_top     (at_top),
      .at_bottom  (at_bottom),
      .fsm_state  (fsm_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int move_y(int y, bit d, int s);
      if (d) return (y + s > YMAX) ? YMAX : y + s;
      return (y < s) ? 0 : y - s;
   endfunction

   function automatic bit m_moving();
      return m_active && (m_frames >= REPEAT_DELAY);
   endfunction

   function automatic logic [1:0] m_state();
      if (!m_active) return 2'd0;
      return m_moving() ? 2'd2 : 2'd1;
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_dir    = 1'b0;
      m_frames = 0;
      m_rsteps = 0;
      m_y      = Y_RESET;
   endtask

   task automatic model_step(input bit uq, input bit ut, input bit dq, input bit dt, input bit ft);
      bit held, opp;
      int s;
      if (!m_active) begin
         if (ut ^ dt) begin
            m_active = 1'b1;
            m_dir    = dt;
            m_frames = 0;
            m_rsteps = 0;
            m_y      = move_y(m_y, dt, STEP);
         end
      end else begin
         held = m_dir ? dq : uq;
         opp  = m_dir ? uq : dq;
         if (!held || opp) begin
            m_active = 1'b0;
         end else if (ft) begin
            m_frames++;
            if (m_frames > REPEAT_DELAY) begin
               s = (ACCEL && m_rsteps >= ACCEL_FRAMES) ? 2 * STEP : STEP;
               m_y = move_y(m_y, m_dir, s);
               m_rsteps++;
            end
         end
      end
   endtask

   // Scoreboard compare of all outputs against one expectation
   task automatic check(input string name, input int ey, input bit em, input logic [1:0] es);
      n_vec++;
      if (paddle_y !== 10'(ey) || moving !== em || fsm_state !== es ||
          at_top !== (ey == 0) || at_bottom !== (ey == YMAX)) begin
         n_err++;
         $display("FAIL %s: got y=%0d mv=%b st=%0d top=%b bot=%b, want y=%0d mv=%b st=%0d top=%b bot=%b",
                  name, paddle_y, moving, fsm_state, at_top, at_bottom,
                  ey, em, es, ey == 0, ey == YMAX);
      end
   endtask

   // Driver: one cycle of inputs, model update at the edge, compare just after it
   task automatic drive(input bit uq, input bit ut, input bit dq, input bit dt, input bit ft);
      @(negedge clk);
      up_q = uq; up_tick = ut; down_q = dq; down_tick = dt; frame_tick = ft;
      @(posedge clk);
      model_step(uq, ut, dq, dt, ft);
      #1;
      check("model", m_y, m_moving(), m_state());
   endtask

   task automatic do_reset();
      @(negedge clk);
      up_q = 0; up_tick = 0; down_q = 0; down_tick = 0; frame_tick = 0;
      reset = 1'b0;
      #2;
      model_reset();
      check("async_reset", Y_RESET, 1'b0, 2'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset_release", Y_RESET, 1'b0, 2'd0);
   endtask

   task automatic hold_frames(input int n, input bit uq, input bit dq);
      for (int i = 0; i < n; i++) begin
         drive(uq, 0, dq, 0, 1);
         drive(uq, 0, dq, 0, 0);
      end
   endtask

   typedef struct {
      logic       uq, ut, dq, dt, ft;
      int         y;
      logic       mv;
      logic [1:0] st;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int exp_y;
      bit ru, rd;
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      up_q = 0; up_tick = 0; down_q = 0; down_tick = 0; frame_tick = 0;
      model_reset();

      tbl[0]  = '{uq:1, ut:1, dq:1, dt:1, ft:0, y:208, mv:0, st:2'd0};
      tbl[1]  = '{uq:0, ut:0, dq:0, dt:0, ft:0, y:208, mv:0, st:2'd0};
      tbl[2]  = '{uq:1, ut:1, dq:0, dt:0, ft:1, y:204, mv:0, st:2'd1};
      tbl[3]  = '{uq:1, ut:0, dq:0, dt:0, ft:1, y:204, mv:0, st:2'd1};
      tbl[4]  = '{uq:0, ut:0, dq:0, dt:0, ft:0, y:204, mv:0, st:2'd0};
      tbl[5]  = '{uq:0, ut:0, dq:1, dt:1, ft:0, y:208, mv:0, st:2'd1};
      tbl[6]  = '{uq:1, ut:0, dq:1, dt:0, ft:0, y:208, mv:0, st:2'd0};
      tbl[7]  = '{uq:0, ut:0, dq:1, dt:0, ft:1, y:208, mv:0, st:2'd0};
      tbl[8]  = '{uq:0, ut:1, dq:0, dt:1, ft:1, y:208, mv:0, st:2'd0};
      tbl[9]  = '{uq:0, ut:0, dq:1, dt:1, ft:1, y:212, mv:0, st:2'd1};
      tbl[10] = '{uq:0, ut:1, dq:0, dt:0, ft:0, y:212, mv:0, st:2'd0};
      tbl[11] = '{uq:0, ut:1, dq:0, dt:0, ft:0, y:208, mv:0, st:2'd1};
      tbl[12] = '{uq:0, ut:0, dq:0, dt:0, ft:0, y:208, mv:0, st:2'd0};

      do_reset();
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].uq, tbl[i].ut, tbl[i].dq, tbl[i].dt, tbl[i].ft);
         check($sformatf("table_%0d", i), tbl[i].y, tbl[i].mv, tbl[i].st);
      end

      // Press, hold delay, repeat steps, release
      do_reset();
      drive(1, 1, 0, 0, 0);
      check("press_up", 204, 0, 2'd1);
      hold_frames(REPEAT_DELAY - 1, 1, 0);
      check("hold_before_repeat", 204, 0, 2'd1);
      hold_frames(1, 1, 0);
      check("enter_repeat", 204, 1, 2'd2);
      hold_frames(3, 1, 0);
      check("repeat_3_steps", 192, 1, 2'd2);
      drive(0, 0, 0, 0, 1);
      check("release_repeat", 192, 0, 2'd0);

      // Opposite level during down repeat freezes the paddle
      do_reset();
      drive(0, 0, 1, 1, 0);
      hold_frames(REPEAT_DELAY + 2, 0, 1);
      check("repeat_down", 220, 1, 2'd2);
      drive(1, 0, 1, 0, 0);
      check("opposite_abort", 220, 0, 2'd0);
      hold_frames(5, 1, 1);
      check("frozen_after_abort", 220, 0, 2'd0);

      // Saturation at top and bottom
      do_reset();
      drive(1, 1, 0, 0, 0);
      hold_frames(REPEAT_DELAY + 60, 1, 0);
      check("top_saturate", 0, 1, 2'd2);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0);
      hold_frames(REPEAT_DELAY + 120, 0, 1);
      check("bottom_saturate", YMAX, 1, 2'd2);

      // Acceleration profile (constant step without the macro)
      do_reset();
      drive(0, 0, 1, 1, 0);
      hold_frames(REPEAT_DELAY, 0, 1);
      exp_y = 212;
      for (int k = 0; k < 12; k++) begin
         hold_frames(1, 0, 1);
         exp_y += (ACCEL && k >= ACCEL_FRAMES) ? 2 * STEP : STEP;
         check($sformatf("accel_step_%0d", k), exp_y, 1, 2'd2);
      end

      // Reset mid-HOLD aborts; held level alone does not restart motion
      do_reset();
      drive(1, 1, 0, 0, 0);
      hold_frames(3, 1, 0);
      do_reset();
      hold_frames(REPEAT_DELAY + 3, 1, 0);
      check("no_motion_after_reset", Y_RESET, 0, 2'd0);

      // Randomized stimulus against the model, with occasional async reset
      ru = 0;
      rd = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            if ($urandom_range(0, 15) == 0) ru = ~ru;
            if ($urandom_range(0, 15) == 0) rd = ~rd;
            drive(ru, $urandom_range(0, 9) == 0, rd, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
